// File: rtl/led_seq.sv
// rtl/led_seq.sv - LED pattern sequencer: rotate, bounce and binary count with prescaled steps.
// Optional PWM brightness gating when LED_SEQ_PWM_EN is defined.
module led_seq #(
    parameter int N_LED          = 6,
    parameter int DIV_CNT        = 13_500_000,
    parameter bit LED_ACTIVE_LOW = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sys_set,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [7:0]       bright,
    output logic             step_o,
    output logic [N_LED-1:0] led
);

    localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(DIV_CNT - 1);
    localparam logic [N_LED-1:0] ONE_MSB = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] ONE_LSB = N_LED'(1);
    localparam logic [N_LED-1:0] UNLIT   = {N_LED{LED_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        M_ROR    = 2'b00,
        M_ROL    = 2'b01,
        M_BOUNCE = 2'b10,
        M_COUNT  = 2'b11
    } mode_t;

    logic [CW-1:0]    cnt;
    logic             tick;
    logic [N_LED-1:0] pattern_q, pattern_d;
    logic             dir_q, dir_d;
    mode_t            mode_q, mode_d, mode_in;
    logic [N_LED-1:0] shown, lit_d;

    assign mode_in = mode_t'(mode);
    assign tick    = (cnt == CNT_MAX) && !pause;

    // A mode change is only sampled on a tick, where it reseeds instead of advancing.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        if (tick) begin
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                case (mode_in)
                    M_ROR:    pattern_d = ONE_MSB;
                    M_ROL:    pattern_d = ONE_LSB;
                    M_BOUNCE: begin
                        pattern_d = ONE_LSB;
                        dir_d     = 1'b1;
                    end
                    default:  pattern_d = '0;
                endcase
            end else begin
                case (mode_q)
                    M_ROR:    pattern_d = {pattern_q[0], pattern_q[N_LED-1:1]};
                    M_ROL:    pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
                    M_BOUNCE: begin
                        // dir_q = 1 walks toward the MSB; end bits turn around without repeating.
                        if (dir_q) begin
                            if (pattern_q[N_LED-1]) begin
                                pattern_d = pattern_q >> 1;
                                dir_d     = 1'b0;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                pattern_d = pattern_q << 1;
                                dir_d     = 1'b1;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
                    default:  pattern_d = pattern_q + 1'b1;
                endcase
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign shown = (pwm_cnt < bright) ? pattern_q : '0;
`else
    logic unused_bright;

    assign unused_bright = ^bright;
    assign shown         = pattern_q;
`endif

    assign lit_d = sys_set ? '1 : shown;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt       <= '0;
            pattern_q <= ONE_MSB;
            dir_q     <= 1'b1;
            mode_q    <= M_ROR;
            step_o    <= 1'b0;
            led       <= UNLIT;
        end else begin
            if (!pause) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            step_o    <= tick;
            led       <= lit_d ^ UNLIT;
        end
    end

endmodule

// File: tb/tb_led_seq.sv
// tb/tb_led_seq.sv - Directed self-checking bench for led_seq (N_LED=6, DIV_CNT=4, active-low).
module tb_led_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       sys_set;
    logic       pause;
    logic [1:0] mode;
    logic [7:0] bright;
    logic       step_o;
    logic [5:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    led_seq #(
        .N_LED         (6),
        .DIV_CNT       (4),
        .LED_ACTIVE_LOW(1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .sys_set(sys_set),
        .pause  (pause),
        .mode   (mode),
        .bright (bright),
        .step_o (step_o),
        .led    (led)
    );

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] m);
        sys_rst = 1'b1;
        sys_set = 1'b0;
        pause   = 1'b0;
        mode    = m;
        cyc();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        sys_set = 1'b1;
        pause   = 1'b1;
        mode    = 2'b11;
        cyc();
        n_checks++;
        if (led !== 6'b111111) begin
            n_fail++;
            $display("FAIL reset_led got=%b exp=%b", led, 6'b111111);
        end
        n_checks++;
        if (step_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_step got=%b exp=0", step_o);
        end
        cyc();
        sys_set = 1'b0;
        pause   = 1'b0;
        mode    = 2'b00;
        cyc();
        sys_rst = 1'b0;
        cyc();
        n_checks++;
        if (led !== 6'b011111) begin
            n_fail++;
            $display("FAIL reset_release_led got=%b exp=%b", led, 6'b011111);
        end
    endtask

    task automatic test_rotate_right();
        logic [5:0] tbl [6];
        int s;
        tbl = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
        apply_reset(2'b00);
        for (int c = 1; c <= 28; c++) begin
            cyc();
            s = (c - 1) / 4;
            n_checks++;
            if (led !== tbl[s % 6]) begin
                n_fail++;
                $display("FAIL ror_led c=%0d got=%b exp=%b", c, led, tbl[s % 6]);
            end
            n_checks++;
            if (step_o !== (c % 4 == 0)) begin
                n_fail++;
                $display("FAIL ror_step c=%0d got=%b exp=%b", c, step_o, (c % 4 == 0));
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] tbl [10];
        logic [5:0] exp_led;
        int s;
        tbl = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111,
                6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101};
        apply_reset(2'b10);
        for (int c = 1; c <= 49; c++) begin
            cyc();
            s = (c - 1) / 4;
            exp_led = (s == 0) ? 6'b011111 : tbl[(s - 1) % 10];
            n_checks++;
            if (led !== exp_led) begin
                n_fail++;
                $display("FAIL bounce_led c=%0d got=%b exp=%b", c, led, exp_led);
            end
        end
    endtask

    task automatic test_count();
        logic [5:0] exp_led;
        int s;
        apply_reset(2'b11);
        for (int c = 1; c <= 4 * 66 + 1; c++) begin
            cyc();
            s = (c - 1) / 4;
            exp_led = (s == 0) ? 6'b011111 : ~6'((s - 1) % 64);
            n_checks++;
            if (led !== exp_led) begin
                n_fail++;
                $display("FAIL count_led c=%0d got=%b exp=%b", c, led, exp_led);
            end
            n_checks++;
            if (step_o !== (c % 4 == 0)) begin
                n_fail++;
                $display("FAIL count_step c=%0d got=%b exp=%b", c, step_o, (c % 4 == 0));
            end
        end
    endtask

    task automatic test_pause_set();
        apply_reset(2'b00);
        repeat (6) cyc();
        n_checks++;
        if (led !== 6'b101111) begin
            n_fail++;
            $display("FAIL pre_pause_led got=%b exp=%b", led, 6'b101111);
        end
        pause = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_checks++;
            if (led !== 6'b101111 || step_o !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold i=%0d led=%b step=%b exp led=101111 step=0", i, led, step_o);
            end
        end
        pause = 1'b0;
        cyc();
        n_checks++;
        if (step_o !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_early_step got=%b exp=0", step_o);
        end
        cyc();
        n_checks++;
        if (step_o !== 1'b1 || led !== 6'b101111) begin
            n_fail++;
            $display("FAIL resume_tick step=%b led=%b exp step=1 led=101111", step_o, led);
        end
        cyc();
        n_checks++;
        if (led !== 6'b110111) begin
            n_fail++;
            $display("FAIL resume_led got=%b exp=%b", led, 6'b110111);
        end
        sys_set = 1'b1;
        cyc();
        n_checks++;
        if (led !== 6'b000000) begin
            n_fail++;
            $display("FAIL set_led got=%b exp=%b", led, 6'b000000);
        end
        sys_set = 1'b0;
        cyc();
        n_checks++;
        if (led !== 6'b110111) begin
            n_fail++;
            $display("FAIL set_release_led got=%b exp=%b", led, 6'b110111);
        end
        sys_set = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (led !== 6'b000000) begin
                n_fail++;
                $display("FAIL set_hold_led i=%0d got=%b exp=000000", i, led);
            end
            if (i == 0) begin
                n_checks++;
                if (step_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL set_hold_step got=%b exp=1", step_o);
                end
            end
        end
        sys_set = 1'b0;
        cyc();
        n_checks++;
        if (led !== 6'b111011) begin
            n_fail++;
            $display("FAIL set_advanced_led got=%b exp=%b", led, 6'b111011);
        end
    endtask

    task automatic test_mode_change();
        apply_reset(2'b00);
        repeat (4) cyc();
        n_checks++;
        if (step_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mc_first_tick step=%b exp=1", step_o);
        end
        cyc();
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (led !== 6'b101111) begin
                n_fail++;
                $display("FAIL mc_hold_led i=%0d got=%b exp=101111", i, led);
            end
        end
        n_checks++;
        if (step_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mc_tick step=%b exp=1", step_o);
        end
        cyc();
        n_checks++;
        if (led !== 6'b111110) begin
            n_fail++;
            $display("FAIL mc_seed_led got=%b exp=%b", led, 6'b111110);
        end
        repeat (4) cyc();
        n_checks++;
        if (led !== 6'b111101) begin
            n_fail++;
            $display("FAIL rol_led got=%b exp=%b", led, 6'b111101);
        end
        cyc();
        sys_rst = 1'b1;
        cyc();
        n_checks++;
        if (led !== 6'b111111 || step_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midstep_reset led=%b step=%b exp led=111111 step=0", led, step_o);
        end
        sys_rst = 1'b0;
        cyc();
        n_checks++;
        if (led !== 6'b011111) begin
            n_fail++;
            $display("FAIL midstep_release_led got=%b exp=%b", led, 6'b011111);
        end
        cyc();
        cyc();
        n_checks++;
        if (step_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midstep_prescale step=%b exp=0", step_o);
        end
        cyc();
        n_checks++;
        if (step_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midstep_tick step=%b exp=1", step_o);
        end
        cyc();
        n_checks++;
        if (led !== 6'b111110) begin
            n_fail++;
            $display("FAIL midstep_seed_led got=%b exp=%b", led, 6'b111110);
        end
    endtask

`ifdef LED_SEQ_PWM_EN
    task automatic test_pwm();
        int low_cnt;
        int bad_cnt;
        sys_rst = 1'b1;
        sys_set = 1'b0;
        pause   = 1'b1;
        mode    = 2'b00;
        bright  = 8'd64;
        cyc();
        sys_rst = 1'b0;
        repeat (4) cyc();
        low_cnt = 0;
        bad_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (led[5] == 1'b0) low_cnt++;
            if (led[4:0] !== 5'b11111) bad_cnt++;
        end
        n_checks++;
        if (low_cnt != 64) begin
            n_fail++;
            $display("FAIL pwm_duty got=%0d exp=64", low_cnt);
        end
        n_checks++;
        if (bad_cnt != 0) begin
            n_fail++;
            $display("FAIL pwm_unlit_bits got=%0d exp=0", bad_cnt);
        end
        bright = 8'd0;
        cyc();
        cyc();
        bad_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (led !== 6'b111111) bad_cnt++;
        end
        n_checks++;
        if (bad_cnt != 0) begin
            n_fail++;
            $display("FAIL pwm_zero got=%0d exp=0", bad_cnt);
        end
        sys_set = 1'b1;
        cyc();
        bad_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (led !== 6'b000000) bad_cnt++;
        end
        n_checks++;
        if (bad_cnt != 0) begin
            n_fail++;
            $display("FAIL pwm_set got=%0d exp=0", bad_cnt);
        end
        sys_set = 1'b0;
        pause   = 1'b0;
    endtask
`endif

    initial begin
        sys_rst = 1'b1;
        sys_set = 1'b0;
        pause   = 1'b0;
        mode    = 2'b00;
        bright  = 8'd0;
        test_reset();
`ifdef LED_SEQ_PWM_EN
        test_pwm();
`else
        test_rotate_right();
        test_bounce();
        test_count();
        test_pause_set();
        test_mode_change();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 Parameter N_LED, default 6: number of LEDs; legal range 2..32.
REQ-002 Parameter DIV_CNT, default 13_500_000: sys_clk cycles per pattern step; minimum 2.
REQ-003 Parameter LED_ACTIVE_LOW, default 1: 1 drives a lit LED as 0, 0 drives a lit LED as 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- sys_clk  in  1  Single clock; all state changes on its rising edge.
- sys_rst  in  1  Synchronous, active-high reset.
- sys_set  in  1  Active-high override: all LEDs lit.
- pause  in  1  Active-high; freezes sequencing.
- mode  in  2  Pattern select: 00 rotate right, 01 rotate left, 10 bounce, 11 binary count.
- bright  in  8  PWM duty; used only with LED_SEQ_PWM_EN.
- step_o  out  1  One-cycle pulse on each pattern step.
- led  out  N_LED  Registered LED drive, polarity per LED_ACTIVE_LOW.

Function
REQ-005 The prescaler SHALL be $clog2(DIV_CNT) bits and count 0..DIV_CNT-1, wrapping to 0; a tick occurs in the cycle where count == DIV_CNT-1 and pause == 0.
REQ-006 While pause == 1, the prescaler, pattern, direction and mode_q SHALL hold, and no tick is generated.
REQ-007 step_o SHALL be registered and equal 1 for exactly one cycle, the cycle after each tick.
REQ-008 The internal pattern register (N_LED bits, 1 = lit) SHALL change only on a tick.
REQ-009 On a tick where mode == mode_q, the pattern SHALL advance as follows.
- 00: rotate right, {p[0], p[N_LED-1:1]}.
- 01: rotate left, {p[N_LED-2:0], p[N_LED-1]}.
- 10: shift one position in the dir direction.
- 11: p+1 modulo 2^N_LED; 2^N_LED-1 wraps to 0.
REQ-010 Bounce (mode 10) SHALL work as follows.
- dir = up moves the lit bit toward the MSB; at bit N_LED-1 the step moves to bit N_LED-2 and sets dir = down.
- It reverses symmetrically at bit 0.
- Period is 2*(N_LED-1) steps; no end bit is repeated.
REQ-011 On a tick where mode != mode_q, the block SHALL set mode_q = mode and load the seed for the new mode instead of advancing.
- 00: one-hot bit N_LED-1.
- 01: one-hot bit 0.
- 10: one-hot bit 0 with dir = up.
- 11: all zeros.
REQ-012 A mode change between ticks SHALL have no effect until the next tick.
REQ-013 led SHALL be registered from the current pattern, one cycle after it, so it shows a new pattern one cycle after the tick.
REQ-014 While sys_set == 1, led SHALL drive all LEDs lit, registered with the same 1-cycle latency; sequencing continues unless paused, and the current pattern reappears one cycle after sys_set deasserts.
REQ-015 Priority SHALL be sys_rst > sys_set (display) > pause > tick.

Reset
REQ-016 sys_rst SHALL take effect only on a sys_clk rising edge and is honoured mid-step, mid-pause and mid-override.
REQ-017 During reset the block SHALL load the following.
- prescaler = 0
- pattern = one-hot bit N_LED-1
- dir = up
- mode_q = 00
- step_o = 0
- led = all LEDs unlit (all ones when LED_ACTIVE_LOW = 1)
- PWM counter = 0
REQ-018 In the first cycle after reset release, led SHALL show the reset pattern.

Configuration
REQ-019 Macro LED_SEQ_PWM_EN, when defined, SHALL add an 8-bit free-running PWM counter (0..255, wrap).
- A pattern bit is shown lit only while pwm_cnt < bright: bright = 0 gives always unlit, 255 gives lit 255 of 256 cycles.
- The PWM gating is applied before the led register.
- sys_set overrides PWM: fully lit.
REQ-020 With LED_SEQ_PWM_EN undefined, the block SHALL have no PWM counter, SHALL ignore bright, and SHALL show lit bits continuously.

Verification (N_LED = 6, DIV_CNT = 4, LED_ACTIVE_LOW = 1)
REQ-021 Reset, then mode = 00: led = 011111 one cycle after release, then 101111, 110111, 111011 ... every 4 cycles, and 011111 again after 6 steps; step_o pulses every 4 cycles.
REQ-022 mode = 10 held from reset: first tick loads seed 111110, then lit bit walks 0 -> 5 -> 0 with period 10 steps and no end repeats.
REQ-023 mode = 11: pattern counts 0..63; on the tick after 111111 (led 000000) it wraps to 000000 (led 111111), with no glitch on step_o.
REQ-024 pause asserted for 3 tick periods mid-sequence: led and step_o frozen, prescaler resumes from its held value. sys_set pulse: led = 000000 one cycle later, previous pattern restored one cycle after release.
REQ-025 mode changed 00 -> 01 one cycle after a tick: no change until the next tick, which loads 000001 (led 111110). sys_rst asserted mid-step: next edge gives the REQ-017 values.
REQ-026 LED_SEQ_PWM_EN defined, bright = 64: each lit LED is low for exactly 64 of every 256 cycles; bright = 0: led all ones; sys_set = 1: led all zeros regardless of bright.
